// File: rtl/even_odd_merge_sorter_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : eoms_compare_exchange / even_odd_merge_sorter_wrapper
//  Description : Four-input Batcher even-odd merge sorter for unsigned 8-bit
//                words. Three compare-exchange stages built from five
//                comparators. One input set is accepted every clock with
//                no handshake.
//
//                PIPELINE = 1 : a register after each stage, latency 3 edges.
//                PIPELINE = 0 : combinational network followed by a single
//                               output register, latency 1 edge.
//
//  Ports (even_odd_merge_sorter_wrapper)
//    clk          in   1  clock, rising edge
//    rst          in   1  synchronous reset, active low
//    A, B, C, D   in   8  unsigned input words
//    max          out  8  largest input
//    second_max   out  8  second largest input
//    second_min   out  8  third largest input
//    min          out  8  smallest input
//
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Compare-exchange cell: routes the larger operand to o_hi and the smaller
// one to o_lo. Unsigned compare, no width growth.
// ----------------------------------------------------------------------------
module eoms_compare_exchange #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic w_x_ge_y;

    assign w_x_ge_y = (i_x >= i_y);
    assign o_hi     = w_x_ge_y ? i_x : i_y;
    assign o_lo     = w_x_ge_y ? i_y : i_x;

endmodule

// ----------------------------------------------------------------------------
// Sorter top level
// ----------------------------------------------------------------------------
module even_odd_merge_sorter_wrapper #(
    parameter int PIPELINE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] C,
    input  logic [7:0] D,
    output logic [7:0] max,
    output logic [7:0] second_max,
    output logic [7:0] second_min,
    output logic [7:0] min
);

    localparam logic [7:0] C_ZERO = 8'h00;

    // Stage 1 results
    logic [7:0] w_s1_h0, w_s1_l0, w_s1_h1, w_s1_l1;
    // Stage 2 operands (registered or straight-through depending on build)
    logic [7:0] w_s2a_h0, w_s2a_l0, w_s2a_h1, w_s2a_l1;
    // Stage 2 results
    logic [7:0] w_s2_max, w_s2_m0, w_s2_m1, w_s2_min;
    // Stage 3 operands
    logic [7:0] w_s3a_max, w_s3a_m0, w_s3a_m1, w_s3a_min;
    // Stage 3 results
    logic [7:0] w_s3_hi, w_s3_lo;

    // ------------------------------------------------------------------
    // Stage 1: sort the pairs (A,B) and (C,D)
    // ------------------------------------------------------------------
    eoms_compare_exchange #(.WIDTH(8)) u_ce_s1_ab (
        .i_x (A),
        .i_y (B),
        .o_hi(w_s1_h0),
        .o_lo(w_s1_l0)
    );

    eoms_compare_exchange #(.WIDTH(8)) u_ce_s1_cd (
        .i_x (C),
        .i_y (D),
        .o_hi(w_s1_h1),
        .o_lo(w_s1_l1)
    );

    // ------------------------------------------------------------------
    // Stage 2: the larger of the two highs is the global max, the smaller
    // of the two lows is the global min; the leftovers go to stage 3.
    // ------------------------------------------------------------------
    eoms_compare_exchange #(.WIDTH(8)) u_ce_s2_hi (
        .i_x (w_s2a_h0),
        .i_y (w_s2a_h1),
        .o_hi(w_s2_max),
        .o_lo(w_s2_m0)
    );

    eoms_compare_exchange #(.WIDTH(8)) u_ce_s2_lo (
        .i_x (w_s2a_l0),
        .i_y (w_s2a_l1),
        .o_hi(w_s2_m1),
        .o_lo(w_s2_min)
    );

    // ------------------------------------------------------------------
    // Stage 3: order the two middle values. max/min ride alongside so all
    // four outputs leave the pipeline together.
    // ------------------------------------------------------------------
    eoms_compare_exchange #(.WIDTH(8)) u_ce_s3_mid (
        .i_x (w_s3a_m0),
        .i_y (w_s3a_m1),
        .o_hi(w_s3_hi),
        .o_lo(w_s3_lo)
    );

    // ------------------------------------------------------------------
    // Inter-stage registers (pipelined build) or direct wiring
    // ------------------------------------------------------------------
    generate
        if (PIPELINE != 0) begin : g_pipe
            logic [7:0] r_s1_h0, r_s1_l0, r_s1_h1, r_s1_l1;
            logic [7:0] r_s2_max, r_s2_m0, r_s2_m1, r_s2_min;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_s1_h0  <= C_ZERO;
                    r_s1_l0  <= C_ZERO;
                    r_s1_h1  <= C_ZERO;
                    r_s1_l1  <= C_ZERO;
                    r_s2_max <= C_ZERO;
                    r_s2_m0  <= C_ZERO;
                    r_s2_m1  <= C_ZERO;
                    r_s2_min <= C_ZERO;
                end else begin
                    r_s1_h0  <= w_s1_h0;
                    r_s1_l0  <= w_s1_l0;
                    r_s1_h1  <= w_s1_h1;
                    r_s1_l1  <= w_s1_l1;
                    r_s2_max <= w_s2_max;
                    r_s2_m0  <= w_s2_m0;
                    r_s2_m1  <= w_s2_m1;
                    r_s2_min <= w_s2_min;
                end
            end

            assign w_s2a_h0  = r_s1_h0;
            assign w_s2a_l0  = r_s1_l0;
            assign w_s2a_h1  = r_s1_h1;
            assign w_s2a_l1  = r_s1_l1;
            assign w_s3a_max = r_s2_max;
            assign w_s3a_m0  = r_s2_m0;
            assign w_s3a_m1  = r_s2_m1;
            assign w_s3a_min = r_s2_min;
        end else begin : g_comb
            assign w_s2a_h0  = w_s1_h0;
            assign w_s2a_l0  = w_s1_l0;
            assign w_s2a_h1  = w_s1_h1;
            assign w_s2a_l1  = w_s1_l1;
            assign w_s3a_max = w_s2_max;
            assign w_s3a_m0  = w_s2_m0;
            assign w_s3a_m1  = w_s2_m1;
            assign w_s3a_min = w_s2_min;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register, present in both builds. Reset wins over capture.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            max        <= C_ZERO;
            second_max <= C_ZERO;
            second_min <= C_ZERO;
            min        <= C_ZERO;
        end else begin
            max        <= w_s3a_max;
            second_max <= w_s3_hi;
            second_min <= w_s3_lo;
            min        <= w_s3a_min;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_even_odd_merge_sorter_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_even_odd_merge_sorter_wrapper
//  Description : Scoreboard bench for the four-input sorter. Both builds
//                (PIPELINE=1 and PIPELINE=0) are instantiated side by side
//                and driven with the same stimulus. The stimulus process
//                works out, from the history of applied sets and resets,
//                what each build must show after the coming edge and queues
//                it; a monitor pops one entry per edge and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_even_odd_merge_sorter_wrapper;

    localparam int C_LAT_P = 3;   // edges from capture to output, pipelined
    localparam int C_LAT_C = 1;   // same for the single-register build

    logic       clk;
    logic       rst;
    logic [7:0] A, B, C, D;
    logic [7:0] p_max, p_smax, p_smin, p_min;
    logic [7:0] c_max, c_smax, c_smin, c_min;

    int total;
    int bad;

    // Expected output per edge, one queue per build
    logic [31:0] exp_p_v[$];
    string       exp_p_t[$];
    logic [31:0] exp_c_v[$];
    string       exp_c_t[$];

    // One entry per clock edge: the sorted set captured at that edge, or
    // zero once a reset has wiped it out.
    logic [31:0] hist_v[$];
    string       hist_t[$];

    even_odd_merge_sorter_wrapper #(.PIPELINE(1)) u_dut_pipe (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .max       (p_max),
        .second_max(p_smax),
        .second_min(p_smin),
        .min       (p_min)
    );

    even_odd_merge_sorter_wrapper #(.PIPELINE(0)) u_dut_comb (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .max       (c_max),
        .second_max(c_smax),
        .second_min(c_smin),
        .min       (c_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sort the four words descending as plain numbers.
    function automatic logic [31:0] ref_sort(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        int unsigned q[$];
        q = '{int'(a), int'(b), int'(c), int'(d)};
        q.rsort();
        return {q[0][7:0], q[1][7:0], q[2][7:0], q[3][7:0]};
    endfunction

    function automatic logic [31:0] expected_at(input int lat);
        int n;
        n = hist_v.size();
        if (n >= lat) return hist_v[n-lat];
        return 32'h0;
    endfunction

    function automatic string tag_at(input int lat);
        int n;
        n = hist_t.size();
        if (n >= lat) return hist_t[n-lat];
        return "fill";
    endfunction

    // Drive one set ahead of the next rising edge and queue what each build
    // must show just after that edge.
    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input string tag);
        @(negedge clk);
        rst = r;
        A = a;
        B = b;
        C = c;
        D = d;
        if (!r) begin
            foreach (hist_v[i]) begin
                hist_v[i] = 32'h0;
                hist_t[i] = "flushed";
            end
            hist_v.push_back(32'h0);
            hist_t.push_back({"reset/", tag});
        end else begin
            hist_v.push_back(ref_sort(a, b, c, d));
            hist_t.push_back(tag);
        end
        exp_p_v.push_back(expected_at(C_LAT_P));
        exp_p_t.push_back(tag_at(C_LAT_P));
        exp_c_v.push_back(expected_at(C_LAT_C));
        exp_c_t.push_back(tag_at(C_LAT_C));
    endtask

    // Monitor: one comparison per build per edge, sampled 1 time unit after
    // the edge.
    initial begin
        logic [31:0] act;
        logic [31:0] ev;
        string       et;
        forever begin
            @(posedge clk);
            #1;
            if (exp_p_v.size() > 0) begin
                ev  = exp_p_v.pop_front();
                et  = exp_p_t.pop_front();
                act = {p_max, p_smax, p_smin, p_min};
                total++;
                if (act !== ev) begin
                    bad++;
                    $display("FAIL pipe[%s]: got %h required %h", et, act, ev);
                end
            end
            if (exp_c_v.size() > 0) begin
                ev  = exp_c_v.pop_front();
                et  = exp_c_t.pop_front();
                act = {c_max, c_smax, c_smin, c_min};
                total++;
                if (act !== ev) begin
                    bad++;
                    $display("FAIL comb[%s]: got %h required %h", et, act, ev);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        A = 8'h00; B = 8'h00; C = 8'h00; D = 8'h00;

        // Reset held for two edges
        apply(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "reset0");
        apply(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "reset1");

        // Directed vectors; outputs must stay 00 while the pipe fills
        apply(1'b1, 8'h12, 8'h34, 8'h56, 8'h78, "ascending");
        apply(1'b1, 8'hFF, 8'h00, 8'h80, 8'h7F, "unsigned_mix");
        apply(1'b1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, "all_equal");
        apply(1'b1, 8'h10, 8'h10, 8'h01, 8'h01, "pair_ties");
        apply(1'b1, 8'h78, 8'h56, 8'h34, 8'h12, "descending");
        apply(1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, "extremes");

        // Streaming random sets
        for (int i = 0; i < 30; i++) begin
            apply(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  $sformatf("rand%0d", i));
        end

        // Single-cycle reset while data is in flight
        apply(1'b0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, "midreset");
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  $sformatf("post%0d", i));
        end

        // Drain with a few more sets so the last ones reach the outputs
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'($urandom_range(0, 15)), 8'($urandom_range(240, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  $sformatf("drain%0d", i));
        end

        @(posedge clk);
        #3;
        if (exp_p_v.size() != 0 || exp_c_v.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d/%0d pending required 0/0",
                     exp_p_v.size(), exp_c_v.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
